bf16_to_sint23: RTL and testbench



---
 rtl/bf16_pkg.sv | 17 +
 rtl/bf16_to_sint23_if.sv | 26 ++
 rtl/bf16_decode_align.sv | 67 ++++++
 rtl/bf16_to_sint23.sv | 148 ++++++++++++++
 tb/tb_bf16_to_sint23.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared BF16 field layout and 23-bit signed-integer limits.
// Used by both the BF16 encoder and the decoder/converter.
package bf16_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] man;
    } bf16_t;

    localparam logic [7:0]  BF16_BIAS    = 8'd127;
    localparam logic [7:0]  BF16_EXP_MAX = 8'd255;

    localparam logic [22:0] SINT23_MAX = 23'h3FFFFF;
    localparam logic [22:0] SINT23_MIN = 23'h400000;

endpackage

// File: rtl/bf16_to_sint23_if.sv
// Valid/ready stream bundle for the BF16 -> signed-integer converter.
// The master side is the producer/consumer; the slave side is the converter.
interface bf16_to_sint23_if #(
    parameter int unsigned INT_W = 23
);

    logic             in_valid;
    logic             in_ready;
    logic [15:0]      bf16_in;
    logic             out_valid;
    logic             out_ready;
    logic [INT_W-1:0] sint_out;
    logic             ovf;
    logic             nan;

    modport master (
        output in_valid, bf16_in, out_ready,
        input  in_ready, out_valid, sint_out, ovf, nan
    );

    modport slave (
        input  in_valid, bf16_in, out_ready,
        output in_ready, out_valid, sint_out, ovf, nan
    );

endinterface

// File: rtl/bf16_decode_align.sv
// Combinational BF16 decode and magnitude alignment (stage 1 of the converter).
// Guard/sticky outputs exist only when BF16_TO_SINT_RNE_EN is defined.
module bf16_decode_align
    import bf16_pkg::*;
(
    input  logic [15:0] bf16_i,
    output logic        sign_o,
    output logic [22:0] mag_o,
    output logic        sat_o,
    output logic        nan_o
`ifdef BF16_TO_SINT_RNE_EN
    ,
    output logic        guard_o,
    output logic        sticky_o
`endif
);

    localparam logic [7:0] ExpSat = BF16_BIAS + 8'd22;
    localparam logic [7:0] ExpShl = BF16_BIAS + 8'd7;

    bf16_t      f;
    logic [7:0] ext;
`ifdef BF16_TO_SINT_RNE_EN
    logic [15:0] frac;
`endif

    assign f   = bf16_i;
    assign ext = {1'b1, f.man};

    always_comb begin
        sign_o = f.sign;
        mag_o  = '0;
        sat_o  = 1'b0;
        nan_o  = 1'b0;
`ifdef BF16_TO_SINT_RNE_EN
        guard_o  = 1'b0;
        sticky_o = 1'b0;
        frac     = '0;
`endif
        if (f.exp == 8'd0) begin
            mag_o = '0;
        end else if (f.exp == BF16_EXP_MAX) begin
            nan_o = (f.man != 7'd0);
            sat_o = (f.man == 7'd0);
        end else if (f.exp >= ExpSat) begin
            // -2^22 is the one value at E==22 that is representable
            if (f.sign && f.exp == ExpSat && f.man == 7'd0) begin
                mag_o = SINT23_MIN;
            end else begin
                sat_o = 1'b1;
            end
        end else if (f.exp >= ExpShl) begin
            mag_o = {15'd0, ext} << (f.exp - ExpShl);
        end else begin
`ifdef BF16_TO_SINT_RNE_EN
            // Low byte of frac holds the shifted-out bits: guard then sticky
            frac     = {ext, 8'd0} >> (ExpShl - f.exp);
            mag_o    = {15'd0, frac[15:8]};
            guard_o  = frac[7];
            sticky_o = |frac[6:0];
`else
            mag_o = {15'd0, ext >> (ExpShl - f.exp)};
`endif
        end
    end

endmodule

// File: rtl/bf16_to_sint23.sv
// Two-stage pipelined, saturating BF16 -> 23-bit signed integer converter.
// Define BF16_TO_SINT_RNE_EN for round-to-nearest-even; default truncates toward zero.
module bf16_to_sint23
    import bf16_pkg::*;
#(
    parameter int unsigned INT_W = 23,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    bf16_to_sint23_if.slave  io,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_cnt
);

    logic             dec_sign, dec_sat, dec_nan;
    logic [INT_W-1:0] dec_mag;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic             s1_sat_q, s1_sat_d;
    logic             s1_nan_q, s1_nan_d;
    logic [INT_W-1:0] s1_mag_q, s1_mag_d;
`ifdef BF16_TO_SINT_RNE_EN
    logic             dec_guard, dec_sticky;
    logic             s1_guard_q, s1_guard_d;
    logic             s1_sticky_q, s1_sticky_d;
`endif

    logic             s2_valid_q, s2_valid_d;
    logic [INT_W-1:0] s2_sint_q, s2_sint_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic             s2_nan_q, s2_nan_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic             s1_en, s2_en;
    logic [INT_W-1:0] mag_rnd;

    bf16_decode_align u_decode (
        .bf16_i   (io.bf16_in),
        .sign_o   (dec_sign),
        .mag_o    (dec_mag),
        .sat_o    (dec_sat),
        .nan_o    (dec_nan)
`ifdef BF16_TO_SINT_RNE_EN
        ,
        .guard_o  (dec_guard),
        .sticky_o (dec_sticky)
`endif
    );

    assign s2_en       = !s2_valid_q || io.out_ready;
    assign s1_en       = !s1_valid_q || s2_en;
    assign io.in_ready = !rst && s1_en;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_sat_d   = s1_sat_q;
        s1_nan_d   = s1_nan_q;
        s1_mag_d   = s1_mag_q;
`ifdef BF16_TO_SINT_RNE_EN
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        mag_rnd     = s1_mag_q + INT_W'(s1_guard_q && (s1_sticky_q || s1_mag_q[0]));
`else
        mag_rnd     = s1_mag_q;
`endif
        s2_valid_d = s2_valid_q;
        s2_sint_d  = s2_sint_q;
        s2_ovf_d   = s2_ovf_q;
        s2_nan_d   = s2_nan_q;

        if (s1_en) begin
            s1_valid_d = io.in_valid;
            s1_sign_d  = dec_sign;
            s1_sat_d   = dec_sat;
            s1_nan_d   = dec_nan;
            s1_mag_d   = dec_mag;
`ifdef BF16_TO_SINT_RNE_EN
            s1_guard_d  = dec_guard;
            s1_sticky_d = dec_sticky;
`endif
        end

        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            s2_ovf_d   = s1_sat_q;
            s2_nan_d   = s1_nan_q;
            if (s1_nan_q) begin
                s2_sint_d = '0;
            end else if (s1_sat_q) begin
                s2_sint_d = s1_sign_q ? SINT23_MIN : SINT23_MAX;
            end else begin
                s2_sint_d = s1_sign_q ? -mag_rnd : mag_rnd;
            end
        end

        // Clear has priority over a same-cycle overflow handoff
        ovf_cnt_d = ovf_cnt_q;
        if (cnt_clr) begin
            ovf_cnt_d = '0;
        end else if (s2_valid_q && io.out_ready && s2_ovf_q && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_sat_q    <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_mag_q    <= '0;
`ifdef BF16_TO_SINT_RNE_EN
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
`endif
            s2_valid_q  <= 1'b0;
            s2_sint_q   <= '0;
            s2_ovf_q    <= 1'b0;
            s2_nan_q    <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_sat_q    <= s1_sat_d;
            s1_nan_q    <= s1_nan_d;
            s1_mag_q    <= s1_mag_d;
`ifdef BF16_TO_SINT_RNE_EN
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
`endif
            s2_valid_q  <= s2_valid_d;
            s2_sint_q   <= s2_sint_d;
            s2_ovf_q    <= s2_ovf_d;
            s2_nan_q    <= s2_nan_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign io.out_valid = s2_valid_q;
    assign io.sint_out  = s2_sint_q;
    assign io.ovf       = s2_ovf_q;
    assign io.nan       = s2_nan_q;
    assign ovf_cnt      = ovf_cnt_q;

endmodule

// File: tb/tb_bf16_to_sint23.sv
// Bench for bf16_to_sint23: directed table, randomized stream vs. real-arithmetic model,
// reset recovery and overflow-counter corner cases (counter built narrow).
module tb_bf16_to_sint23;

    localparam int unsigned INT_W = 23;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] ovf_cnt;

    always #5 clk = ~clk;

    bf16_to_sint23_if #(.INT_W(INT_W)) bus ();

    bf16_to_sint23 #(
        .INT_W (INT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .io      (bus.slave),
        .cnt_clr (cnt_clr),
        .ovf_cnt (ovf_cnt)
    );

    typedef struct packed {
        logic [22:0] sint;
        logic        ovf;
        logic        nan;
    } res_t;

    typedef struct {
        logic [15:0] in;
        logic [22:0] sint;
        logic        ovf;
        logic        nan;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    bit   rnd_ready = 1'b0;
    bit   ready_fixed = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Value computed with real arithmetic straight from the format definition
    function automatic res_t ref_model(input logic [15:0] x);
        res_t r;
        logic s;
        int   ex, mn, e, m;
        real  mag, fl;
        r  = '0;
        s  = x[15];
        ex = int'(x[14:7]);
        mn = int'(x[6:0]);
        if (ex == 0) return r;
        if (ex == 255) begin
            if (mn != 0) begin
                r.nan = 1'b1;
            end else begin
                r.ovf  = 1'b1;
                r.sint = s ? 23'h400000 : 23'h3FFFFF;
            end
            return r;
        end
        e   = ex - 127;
        mag = real'(128 + mn) * (2.0 ** real'(e - 7));
        if (mag >= 4194304.0) begin
            if (s && mag == 4194304.0) begin
                r.sint = 23'h400000;
            end else begin
                r.ovf  = 1'b1;
                r.sint = s ? 23'h400000 : 23'h3FFFFF;
            end
            return r;
        end
        fl = $floor(mag);
        m  = $rtoi(fl);
`ifdef BF16_TO_SINT_RNE_EN
        if ((mag - fl) > 0.5 || ((mag - fl) == 0.5 && (m % 2) == 1)) m = m + 1;
`endif
        if (s) m = -m;
        r.sint = 23'(m);
        return r;
    endfunction

    function automatic logic [15:0] rand_bf16();
        logic [15:0] x;
        x = 16'($urandom);
        if ($urandom_range(0, 3) != 0) x[14:7] = 8'($urandom_range(118, 152));
        return x;
    endfunction

    // Consumer-side ready: random or fixed, changed just after each rising edge
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    // Output monitor: scoreboard order check and hold-while-stalled check
    initial begin
        res_t cur, held, e;
        bit   stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            cur = {bus.sint_out, bus.ovf, bus.nan};
            if (rst) begin
                exp_q.delete();
                stalled = 1'b0;
            end else begin
                if (stalled && bus.out_valid) check("stall_hold", 32'(cur), 32'(held));
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_out: got 0x%0h expected no output", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_data", 32'(cur), 32'(e));
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                held    = cur;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Call aligned just after a rising edge; returns aligned the same way
    task automatic send(input logic [15:0] v);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.bf16_in  = v;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(ref_model(v));
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 for 0x%0h", v);
        end
    endtask

    task automatic send_one(input vec_t v);
        bit got;
        got = 1'b0;
        send(v.in);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                check("latency", 32'(n), 32'd2);
                check("tbl_sint", 32'(bus.sint_out), 32'(v.sint));
                check("tbl_ovf", 32'(bus.ovf), 32'(v.ovf));
                check("tbl_nan", 32'(bus.nan), 32'(v.nan));
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL tbl_timeout: got no out_valid expected one for 0x%0h", v.in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[13];
        tbl[0]  = '{16'h3F80, 23'h000001, 1'b0, 1'b0};
        tbl[1]  = '{16'hC040, 23'h7FFFFD, 1'b0, 1'b0};
        tbl[2]  = '{16'h0000, 23'h000000, 1'b0, 1'b0};
        tbl[3]  = '{16'h0001, 23'h000000, 1'b0, 1'b0};
        tbl[4]  = '{16'h4A80, 23'h3FFFFF, 1'b1, 1'b0};
        tbl[5]  = '{16'hFF80, 23'h400000, 1'b1, 1'b0};
        tbl[6]  = '{16'hCA80, 23'h400000, 1'b0, 1'b0};
        tbl[7]  = '{16'h7FC1, 23'h000000, 1'b0, 1'b1};
        tbl[8]  = '{16'h4020, 23'h000002, 1'b0, 1'b0};
        tbl[9]  = '{16'h3F00, 23'h000000, 1'b0, 1'b0};
`ifdef BF16_TO_SINT_RNE_EN
        tbl[10] = '{16'h4060, 23'h000004, 1'b0, 1'b0};
        tbl[11] = '{16'h3F40, 23'h000001, 1'b0, 1'b0};
        tbl[12] = '{16'hC060, 23'h7FFFFC, 1'b0, 1'b0};
`else
        tbl[10] = '{16'h4060, 23'h000003, 1'b0, 1'b0};
        tbl[11] = '{16'h3F40, 23'h000000, 1'b0, 1'b0};
        tbl[12] = '{16'hC060, 23'h7FFFFD, 1'b0, 1'b0};
`endif

        bus.in_valid = 1'b0;
        bus.bf16_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_sint", 32'(bus.sint_out), 32'd0);
        check("rst_flags", 32'({bus.ovf, bus.nan}), 32'd0);
        check("rst_cnt", 32'(ovf_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) send_one(tbl[i]);
        check("cnt_two_ovf", 32'(ovf_cnt), 32'd2);

        // Random stream under random back-pressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(rand_bf16());
        for (int i = 0; i < 150; i++) begin
            send(rand_bf16());
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rnd_ready = 1'b0;
        @(posedge clk);
        #1;

        // Fill both stages while stalled, then reset mid-stream
        ready_fixed = 1'b0;
        @(posedge clk);
        #1;
        send(16'h3F80);
        send(16'h4040);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("midrst_in_ready_hold", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_fixed = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_cnt", 32'(ovf_cnt), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        send_one(tbl[1]);
        send_one(tbl[0]);

        // Counter saturation with a narrow counter
        for (int i = 0; i < (1 << CNT_W) + 3; i++) send(16'h7F80);
        drain();
        check("cnt_saturated", 32'(ovf_cnt), 32'hF);

        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("cnt_cleared", 32'(ovf_cnt), 32'd0);
        send(16'hFF80);
        drain();
        check("cnt_one", 32'(ovf_cnt), 32'd1);

        // Clear coincident with an overflow handoff
        send(16'h7F80);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (bus.out_valid && bus.out_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL clr_handoff_timeout: got no handoff expected one");
            end
        end
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("cnt_clr_wins", 32'(ovf_cnt), 32'd0);
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
